halt_unit: RTL

- Synthesizable producer of the CPU's end-of-program signals, consumed by the simulation cycle monitor and by FPGA status logic.
- Detects a halt instruction retiring in writeback, freezes the pipeline and waits for outstanding memory traffic to drain.
- Captures the return value from r1 and raises isHalt with a stable ret_val.
- Also counts run cycles and raises a timeout if no halt retires within a bound.

---
 rtl/halt_unit_if.sv | 43 ++++
 rtl/halt_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/halt_unit_if.sv
// Handshake bundle between the pipeline and the halt unit.
// The pipeline (master) drives retire/memory status; the halt unit reports.
interface halt_unit_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
);
  logic              wb_valid;
  logic              wb_is_halt;
  logic              mem_busy;
  logic [DATA_W-1:0] reg_r1;
  logic              stall_all;
  logic              isHalt;
  logic [DATA_W-1:0] ret_val;
  logic              timeout;
  logic              drain_err;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output wb_valid,
    output wb_is_halt,
    output mem_busy,
    output reg_r1,
    input  stall_all,
    input  isHalt,
    input  ret_val,
    input  timeout,
    input  drain_err,
    input  cycle_count
  );

  modport slave (
    input  wb_valid,
    input  wb_is_halt,
    input  mem_busy,
    input  reg_r1,
    output stall_all,
    output isHalt,
    output ret_val,
    output timeout,
    output drain_err,
    output cycle_count
  );
endinterface

// File: rtl/halt_unit.sv
// End-of-program detector: freezes the pipeline on a retiring halt,
// drains memory, captures r1 and reports halt/timeout status.
module halt_unit #(
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 32,
  parameter int TIMEOUT   = 500000,
  parameter int DRAIN_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  halt_unit_if.slave  hu
);

  localparam int DW = $clog2(DRAIN_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT - 1);
  localparam logic [DW-1:0] DRN_LAST =
    DW'(DRAIN_MAX - 1);

  typedef enum logic [2:0] {
    RUN,
    DRAIN,
    CAPTURE,
    HALTED,
    TIMED_OUT
  } state_t;

  state_t            state;
  logic [DW-1:0]     drain_cnt;
  logic              drain_hit;
  logic              is_halt_q;
  logic              timeout_q;
  logic              drain_err_q;
  logic [DATA_W-1:0] ret_val_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              halt_req;
  logic              in_run;

  assign halt_req = hu.wb_valid & hu.wb_is_halt;
  assign in_run   = (state == RUN);

  // Combinational so the instruction behind the halt never advances.
  assign hu.stall_all   = ~in_run | (halt_req & in_run);
  assign hu.isHalt      = is_halt_q;
  assign hu.timeout     = timeout_q;
  assign hu.drain_err   = drain_err_q;
  assign hu.ret_val     = ret_val_q;
  assign hu.cycle_count = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      drain_cnt   <= '0;
      drain_hit   <= 1'b0;
      is_halt_q   <= 1'b0;
      timeout_q   <= 1'b0;
      drain_err_q <= 1'b0;
      ret_val_q   <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (halt_req) begin
            state <= DRAIN;
          end else if (cnt_q == CNT_LAST) begin
            state     <= TIMED_OUT;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (!hu.mem_busy) begin
            state <= CAPTURE;
          end else if (drain_cnt == DRN_LAST) begin
            // Give up on a hung memory but still report a result.
            drain_hit <= 1'b1;
            state     <= CAPTURE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          ret_val_q   <= hu.reg_r1;
          is_halt_q   <= 1'b1;
          drain_err_q <= drain_hit;
          state       <= HALTED;
        end
        HALTED: begin
          state <= HALTED;
        end
        TIMED_OUT: begin
          state <= TIMED_OUT;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule
